// File: rtl/cyclic_queue_ctrl.sv
// Ring-buffer controller: head/tail pointers with wrap bits, entry storage, occupancy and error flags.
// Optional synchronous flush port is enabled by defining CYCQ_FLUSH_EN.
module cyclic_queue_ctrl #(
  parameter int unsigned LOG_DEPTH  = 3,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef CYCQ_FLUSH_EN
  input  logic                  flush_i,
`endif
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [LOG_DEPTH-1:0]  head_idx_o,
  output logic [LOG_DEPTH-1:0]  tail_idx_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [LOG_DEPTH:0]    count_o,
  output logic                  overflow_err_o,
  output logic                  underflow_err_o
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;
  localparam int unsigned PTR_W = LOG_DEPTH + 1;

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic flush_c;
  logic push_acc_c;
  logic pop_acc_c;

`ifdef CYCQ_FLUSH_EN
  assign flush_c = flush_i;
`else
  assign flush_c = 1'b0;
`endif

  // Flags decode the registered pointers so they always agree with the index outputs.
  assign head_idx_o      = head_q[LOG_DEPTH-1:0];
  assign tail_idx_o      = tail_q[LOG_DEPTH-1:0];
  assign empty_o         = (head_q == tail_q);
  assign full_o          = (head_idx_o == tail_idx_o) && (head_q[LOG_DEPTH] != tail_q[LOG_DEPTH]);
  assign count_o         = PTR_W'(tail_q - head_q);
  assign head_data_o     = mem_q[head_idx_o];
  assign overflow_err_o  = ovf_q;
  assign underflow_err_o = unf_q;

  assign push_acc_c = push_i && !full_o && !flush_c;
  assign pop_acc_c  = pop_i && !empty_o && !flush_c;

  // Next-state: flush pulls head onto tail and suppresses both requests and their error reporting.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (flush_c) begin
      head_d = tail_q;
    end else begin
      if (push_acc_c) tail_d = tail_q + PTR_W'(1);
      if (pop_acc_c)  head_d = head_q + PTR_W'(1);
      if (push_i && full_o) ovf_d = 1'b1;
      if (pop_i && empty_o) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Storage is not reset; a write in a reset cycle is discarded along with the push.
  always_ff @(posedge clk) begin
    if (!rst && push_acc_c) mem_q[tail_idx_o] <= push_data_i;
  end

endmodule

// File: tb/tb_cyclic_queue_ctrl.sv
// Directed self-checking bench for cyclic_queue_ctrl at LOG_DEPTH=3, DATA_WIDTH=32.
// Flush scenarios are compiled in when CYCQ_FLUSH_EN is defined.
module tb_cyclic_queue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        push = 1'b0;
  logic [31:0] push_data = '0;
  logic        pop = 1'b0;
  logic [31:0] head_data;
  logic [2:0]  head_idx, tail_idx;
  logic        empty, full, ovf, unf;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;

  cyclic_queue_ctrl #(.LOG_DEPTH(3), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef CYCQ_FLUSH_EN
    .flush_i        (flush),
`endif
    .push_i         (push),
    .push_data_i    (push_data),
    .pop_i          (pop),
    .head_data_o    (head_data),
    .head_idx_o     (head_idx),
    .tail_idx_o     (tail_idx),
    .empty_o        (empty),
    .full_o         (full),
    .count_o        (count),
    .overflow_err_o (ovf),
    .underflow_err_o(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock with the currently driven inputs; outputs are settled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"},  32'(full),  32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_head"},  32'(head_idx), 32'd0);
    chk({tag, "_tail"},  32'(tail_idx), 32'd0);
    chk({tag, "_ovf"},   32'(ovf), 32'd0);
    chk({tag, "_unf"},   32'(unf), 32'd0);
  endtask

  initial begin
    // Reset values
    do_reset();
    check_reset_state("rst");

    // Single push into empty queue
    push = 1'b1; push_data = 32'hA5;
    cyc();
    push = 1'b0;
    chk("p1_empty", 32'(empty), 32'd0);
    chk("p1_count", 32'(count), 32'd1);
    chk("p1_hdata", head_data, 32'hA5);
    chk("p1_head",  32'(head_idx), 32'd0);
    chk("p1_tail",  32'(tail_idx), 32'd1);

    // Fill to full, then overflow push, then push+pop while full
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; push_data = 32'(i);
      cyc();
    end
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_head",  32'(head_idx), 32'd0);
    chk("fill_tail",  32'(tail_idx), 32'd0);
    chk("fill_empty", 32'(empty), 32'd0);
    push_data = 32'hFF;
    cyc();
    chk("ovf_flag",  32'(ovf),   32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_full",  32'(full),  32'd1);
    push_data = 32'hEE; pop = 1'b1;
    cyc();
    chk("fullpp_count", 32'(count), 32'd7);
    chk("fullpp_hdata", head_data, 32'd1);
    push = 1'b0;
    for (int i = 1; i < 8; i++) begin
      chk("drain_hdata", head_data, 32'(i));
      cyc();
    end
    pop = 1'b0;
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_unf",   32'(unf),   32'd0);
    chk("drain_ovf",   32'(ovf),   32'd1);

    // Steady push/pop through the wrap point
    do_reset();
    push = 1'b1; push_data = 32'd0;
    cyc();
    for (int i = 1; i <= 10; i++) begin
      chk("wrap_hdata", head_data, 32'(i - 1));
      push_data = 32'(i); pop = 1'b1;
      cyc();
      chk("wrap_tail",  32'(tail_idx), 32'((i + 1) % 8));
      chk("wrap_count", 32'(count), 32'd1);
    end
    push = 1'b0;
    chk("wrap_last", head_data, 32'd10);
    cyc();
    pop = 1'b0;
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("wrap_head",  32'(head_idx), 32'd3);
    chk("wrap_full",  32'(full), 32'd0);

    // Simultaneous push/pop at count=4
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; push_data = 32'(20 + i);
      cyc();
    end
    pop = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("pp_hdata", head_data, 32'(20 + k));
      push_data = 32'(24 + k);
      cyc();
      chk("pp_count", 32'(count), 32'd4);
    end
    push = 1'b0; pop = 1'b0;
    chk("pp_head", 32'(head_idx), 32'd5);
    chk("pp_tail", 32'(tail_idx), 32'd1);
    chk("pp_next", head_data, 32'd25);

    // Pop while empty with simultaneous push
    do_reset();
    push = 1'b1; pop = 1'b1; push_data = 32'h11;
    cyc();
    push = 1'b0; pop = 1'b0;
    chk("unf_flag",  32'(unf),   32'd1);
    chk("unf_count", 32'(count), 32'd1);
    chk("unf_hdata", head_data,  32'h11);
    chk("unf_ovf",   32'(ovf),   32'd0);
    pop = 1'b1;
    cyc();
    pop = 1'b0;
    chk("unf_sticky", 32'(unf),   32'd1);
    chk("unf_empty",  32'(empty), 32'd1);

`ifdef CYCQ_FLUSH_EN
    // Flush with push from count=5, then reset mid-traffic
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; push_data = 32'(40 + i);
      cyc();
    end
    flush = 1'b1; push_data = 32'h99;
    cyc();
    flush = 1'b0;
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_head",  32'(head_idx), 32'd5);
    chk("fl_tail",  32'(tail_idx), 32'd5);
    chk("fl_ovf",   32'(ovf), 32'd0);
    push_data = 32'h77;
    cyc();
    pop = 1'b1; push_data = 32'h78;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; push = 1'b0; pop = 1'b0;
    check_reset_state("flrst");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
